sd_dat_tx_serializer: RTL and testbench
=======================================

# sd_dat_tx_serializer

Transmit-side neighbour of the DAT receive deserializer. It takes N-bit words from the write-data buffer through a valid/ready handshake and frames them into one SD data block: a start nibble, BLOCK_WORDS words shifted out M bits per sd_clock (MSB nibble first), then an end nibble. It drives the DAT pads and their output enable. CRC generation is a separate downstream stage and is not part of this block.

## Interface
Parameters:
- N, 32, parallel word width; must be a multiple of M
- M, 4, DAT bus width (1 or 4)
- BLOCK_WORDS, 128, words per block (512 bytes at N=32)

Ports:
- sd_clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; 0 = in reset
- start  in  1  one-cycle request to send one block
- word_in  in  N  write data
- word_valid  in  1  word_in is valid
- word_ready  out  1  holding register is empty; a word is accepted when word_valid && word_ready
- serial  out  M  DAT line values
- dat_oe  out  1  DAT output enable
- busy  out  1  a block is in progress
- complete  out  1  one-cycle pulse, coincides with the end nibble
- underrun  out  1  sticky; block aborted because data was missing; cleared by the next accepted start

## Operation
- Storage is a one-word holding register (hold, hold_full) plus an N-bit shift register.
- Nibble counter 0..N/M-1; word counter 0..BLOCK_WORDS-1.
- word_ready = !hold_full, combinational. A word may be preloaded in IDLE.
- FSM states: IDLE, START, DATA, END.
- IDLE: serial = all ones, dat_oe = 0, busy = 0.
  - start = 1 → START, underrun cleared.
  - start while busy is ignored.
- START (1 cycle): serial = 0, dat_oe = 1.
  - If hold_full: move hold into the shift register, clear hold_full, go to DATA.
  - Otherwise: set underrun and return to IDLE with dat_oe = 0.
- DATA: serial = shift[N-1 -: M]; shift left by M each cycle.
  - On the nibble N/M-1 cycle of a word that is not the last: if hold_full, reload the shift register from hold; otherwise set underrun, go to IDLE, drop dat_oe, discard hold.
  - After the last nibble of word BLOCK_WORDS-1 → END.
- END (1 cycle): serial = all ones, dat_oe = 1, complete = 1, then IDLE.
- A word accepted during the last word of a block stays in hold for the next block.
- A load into hold and a transfer out of hold never coincide, because word_ready is low while hold_full.
- reset asserted at any time, including mid-block: immediate return to IDLE; hold cleared; counters cleared.

## Timing
- Reset values: serial = all ones, dat_oe = 0, busy = 0, complete = 0, underrun = 0, word_ready = 1.
- serial, dat_oe, busy, complete and underrun are registered.
- start sampled at edge k:
  - edge k+1: start nibble on serial.
  - edges k+2 .. k+1+BLOCK_WORDS·N/M: data nibbles.
  - next edge: end nibble with complete.
  - busy is high for exactly BLOCK_WORDS·N/M + 2 cycles.
- Data deadlines: word 0 must be in hold by the START cycle. Each later word must be in hold by the last-nibble cycle of the previous word, giving N/M−1 cycles of slack after the transfer.
- underrun rises in the same cycle that dat_oe falls.
- complete is never asserted on an aborted block.

## Structure
- Shared package sd_dat_pkg holds:
  - the FSM state enum (IDLE, START, DATA, END);
  - constants DAT_IDLE_NIBBLE (all ones) and DAT_START_NIBBLE (zero);
  - default N, M and BLOCK_WORDS, also used by the receive deserializer.
- One natural sub-module: sd_dat_word_buffer, the holding register with its valid/ready handshake (load, take, full, flush). The FSM, counters and shift register stay in the top module.

## Test plan
- BLOCK_WORDS=2, words 0x12345678 and 0x9ABCDEF0 preloaded, start pulse → serial 0, then 1,2,3,4,5,6,7,8,9,A,B,C,D,E,F,0, then F with complete=1; busy high for 18 cycles; dat_oe high over the same span.
- Reset deasserted, no stimulus → serial=F, dat_oe=0, word_ready=1, complete=0, underrun=0.
- start with hold empty → underrun=1 one cycle after the start nibble; dat_oe=0; no complete; next start with data present clears underrun.
- Second word withheld until after the first word's last nibble → abort at that boundary: underrun=1, IDLE, hold flushed.
- reset asserted after the 5th data nibble → outputs immediately at reset values; a following start with fresh data sends a complete, correct block.
- start re-pulsed mid-block, plus a word presented during the last word → block unchanged; the extra word is held and sent as word 0 of the next block.

Source files
------------

// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT transmit serializer and receive deserializer.
package sd_dat_pkg;

  localparam int unsigned SD_DAT_N           = 32;
  localparam int unsigned SD_DAT_M           = 4;
  localparam int unsigned SD_DAT_BLOCK_WORDS = 128;

  localparam logic [3:0] DAT_IDLE_NIBBLE  = 4'hF;
  localparam logic [3:0] DAT_START_NIBBLE = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    END
  } dat_state_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_dat_tx_serializer_if.sv
// Write-data handshake between the write buffer (master) and the serializer (slave).
interface sd_dat_tx_serializer_if
  import sd_dat_pkg::*;
#(
  parameter int unsigned N = SD_DAT_N
) ();

  logic [N-1:0] word_in;
  logic         word_valid;
  logic         word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);

endinterface

// File: rtl/sd_dat_word_buffer.sv
// One-word holding register between the write handshake and the shift register.
module sd_dat_word_buffer
  import sd_dat_pkg::*;
#(
  parameter int unsigned N = SD_DAT_N
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic [N-1:0] load_data,
  input  logic         load_valid,
  input  logic         take,
  input  logic         flush,
  output logic [N-1:0] hold,
  output logic         full
);

  logic load;

  assign load = load_valid && !full;

  // A flush also discards a word arriving on the same edge.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      hold <= '0;
      full <= 1'b0;
    end else if (flush || take) begin
      full <= 1'b0;
    end else if (load) begin
      hold <= load_data;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/sd_dat_tx_serializer.sv
// Frames buffered N-bit words into one SD DAT block: start nibble, data, end nibble.
module sd_dat_tx_serializer
  import sd_dat_pkg::*;
#(
  parameter int unsigned N           = SD_DAT_N,
  parameter int unsigned M           = SD_DAT_M,
  parameter int unsigned BLOCK_WORDS = SD_DAT_BLOCK_WORDS
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  input  logic                   start,
  sd_dat_tx_serializer_if.slave  wbuf,
  output logic [M-1:0]           serial,
  output logic                   dat_oe,
  output logic                   busy,
  output logic                   complete,
  output logic                   underrun
);

  localparam int unsigned NIBS  = N / M;
  localparam int unsigned NIB_W = cnt_width(NIBS);
  localparam int unsigned WRD_W = cnt_width(BLOCK_WORDS);
  localparam logic [NIB_W-1:0] LAST_NIB  = NIB_W'(NIBS - 1);
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(BLOCK_WORDS - 1);

  dat_state_e       state;
  logic [N-1:0]     shift;
  logic [NIB_W-1:0] nib_cnt;
  logic [WRD_W-1:0] word_cnt;
  logic [N-1:0]     hold;
  logic             hold_full;
  logic             take;
  logic             flush;

  assign wbuf.word_ready = !hold_full;

  sd_dat_word_buffer #(.N(N)) u_word_buffer (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .load_data  (wbuf.word_in),
    .load_valid (wbuf.word_valid),
    .take       (take),
    .flush      (flush),
    .hold       (hold),
    .full       (hold_full)
  );

  // Word boundaries: the hold register either feeds the shift register or the block aborts.
  always_comb begin
    take  = 1'b0;
    flush = 1'b0;
    case (state)
      START: take = hold_full;
      DATA: begin
        if (nib_cnt == LAST_NIB && word_cnt != LAST_WORD) begin
          take  = hold_full;
          flush = !hold_full;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '0;
      nib_cnt  <= '0;
      word_cnt <= '0;
      serial   <= DAT_IDLE_NIBBLE[M-1:0];
      dat_oe   <= 1'b0;
      busy     <= 1'b0;
      complete <= 1'b0;
      underrun <= 1'b0;
    end else begin
      complete <= 1'b0;
      case (state)
        IDLE: begin
          serial <= DAT_IDLE_NIBBLE[M-1:0];
          dat_oe <= 1'b0;
          busy   <= 1'b0;
          if (start) begin
            state    <= START;
            underrun <= 1'b0;
            serial   <= DAT_START_NIBBLE[M-1:0];
            dat_oe   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (hold_full) begin
            state    <= DATA;
            serial   <= hold[N-1 -: M];
            shift    <= hold << M;
            nib_cnt  <= '0;
            word_cnt <= '0;
          end else begin
            state    <= IDLE;
            underrun <= 1'b1;
            serial   <= DAT_IDLE_NIBBLE[M-1:0];
            dat_oe   <= 1'b0;
            busy     <= 1'b0;
          end
        end
        DATA: begin
          if (nib_cnt != LAST_NIB) begin
            serial  <= shift[N-1 -: M];
            shift   <= shift << M;
            nib_cnt <= nib_cnt + NIB_W'(1);
          end else if (word_cnt == LAST_WORD) begin
            state    <= END;
            serial   <= DAT_IDLE_NIBBLE[M-1:0];
            complete <= 1'b1;
          end else if (hold_full) begin
            serial   <= hold[N-1 -: M];
            shift    <= hold << M;
            nib_cnt  <= '0;
            word_cnt <= word_cnt + WRD_W'(1);
          end else begin
            state    <= IDLE;
            underrun <= 1'b1;
            serial   <= DAT_IDLE_NIBBLE[M-1:0];
            dat_oe   <= 1'b0;
            busy     <= 1'b0;
          end
        end
        END: begin
          state  <= IDLE;
          serial <= DAT_IDLE_NIBBLE[M-1:0];
          dat_oe <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_tx_serializer.sv
// Directed and randomized checks of sd_dat_tx_serializer against a nibble-stream model.
module tb_sd_dat_tx_serializer;

  localparam int N    = 32;
  localparam int M    = 4;
  localparam int BW   = 2;
  localparam int NIBS = N / M;

  typedef struct {
    logic [3:0] ser;
    logic       oe;
    logic       bsy;
    logic       cmp;
    logic       und;
  } exp_t;

  logic         sd_clock = 1'b0;
  logic         reset    = 1'b0;
  logic         start    = 1'b0;
  logic [M-1:0] serial;
  logic         dat_oe;
  logic         busy;
  logic         complete;
  logic         underrun;
  logic         accepted;

  int total = 0;
  int bad   = 0;

  exp_t        expq[$];
  logic [31:0] feed[$];
  logic [31:0] words[$];

  sd_dat_tx_serializer_if #(.N(N)) bus ();

  sd_dat_tx_serializer #(.N(N), .M(M), .BLOCK_WORDS(BW)) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .start    (start),
    .wbuf     (bus.slave),
    .serial   (serial),
    .dat_oe   (dat_oe),
    .busy     (busy),
    .complete (complete),
    .underrun (underrun)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic drive_feed();
    if (feed.size() > 0) begin
      bus.word_valid = 1'b1;
      bus.word_in    = feed[0];
    end else begin
      bus.word_valid = 1'b0;
      bus.word_in    = $urandom;
    end
  endtask

  // One clock: note handshake acceptance, step past the edge, update stimulus.
  task automatic cycle();
    @(negedge sd_clock);
    accepted = bus.word_valid && bus.word_ready;
    @(posedge sd_clock);
    #1;
    start = 1'b0;
    if (accepted) void'(feed.pop_front());
    drive_feed();
  endtask

  // Expected per-cycle outputs for one block when only `avail` words arrive in time.
  function automatic void model_block(input logic [31:0] w[$], input int avail);
    logic [31:0] sh;
    expq.push_back('{4'h0, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int wi = 0; wi < BW; wi++) begin
      if (wi >= avail) begin
        expq.push_back('{4'hF, 1'b0, 1'b0, 1'b0, 1'b1});
        return;
      end
      for (int i = 0; i < NIBS; i++) begin
        sh = w[wi] >> (N - M * (i + 1));
        expq.push_back('{sh[3:0], 1'b1, 1'b1, 1'b0, 1'b0});
      end
    end
    expq.push_back('{4'hF, 1'b1, 1'b1, 1'b1, 1'b0});
    expq.push_back('{4'hF, 1'b0, 1'b0, 1'b0, 1'b0});
  endfunction

  task automatic run_expect(input string tag, input int limit, input int hook_idx,
                            input logic [31:0] hook_word, input int start_idx);
    exp_t e;
    int   idx = 0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      chk({tag, " serial"}, 32'(serial), 32'(e.ser));
      chk({tag, " dat_oe"}, 32'(dat_oe), 32'(e.oe));
      chk({tag, " busy"}, 32'(busy), 32'(e.bsy));
      chk({tag, " complete"}, 32'(complete), 32'(e.cmp));
      chk({tag, " underrun"}, 32'(underrun), 32'(e.und));
      if (idx == hook_idx) begin
        feed.push_back(hook_word);
        drive_feed();
      end
      if (idx == start_idx) start = 1'b1;
      if (idx + 1 == limit) break;
      cycle();
      idx++;
    end
    expq.delete();
  endtask

  task automatic preload_two(output logic [31:0] w0, output logic [31:0] w1);
    w0 = $urandom;
    w1 = $urandom;
    feed.push_back(w0);
    feed.push_back(w1);
    drive_feed();
    cycle();
    cycle();
  endtask

  initial begin
    logic [31:0] a, b, c, d;
    drive_feed();
    repeat (3) @(posedge sd_clock);
    #1;
    reset = 1'b1;
    cycle();
    chk("reset serial", 32'(serial), 32'hF);
    chk("reset dat_oe", 32'(dat_oe), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset complete", 32'(complete), 32'h0);
    chk("reset underrun", 32'(underrun), 32'h0);
    chk("reset word_ready", 32'(bus.word_ready), 32'h1);

    // Known-answer block.
    feed.push_back(32'h12345678);
    feed.push_back(32'h9ABCDEF0);
    drive_feed();
    cycle();
    cycle();
    chk("preload word_ready", 32'(bus.word_ready), 32'h0);
    words = '{32'h12345678, 32'h9ABCDEF0};
    model_block(words, 2);
    start = 1'b1;
    cycle();
    run_expect("kat", -1, -1, 32'h0, -1);

    // Start with nothing in hold.
    words.delete();
    model_block(words, 0);
    start = 1'b1;
    cycle();
    run_expect("empty", -1, -1, 32'h0, -1);
    cycle();
    chk("empty underrun sticky", 32'(underrun), 32'h1);
    preload_two(a, b);
    chk("empty underrun held", 32'(underrun), 32'h1);
    words = '{a, b};
    model_block(words, 2);
    start = 1'b1;
    cycle();
    run_expect("recover", -1, -1, 32'h0, -1);

    // Second word arrives one cycle too late: abort and flush.
    a = $urandom;
    b = $urandom;
    feed.push_back(a);
    drive_feed();
    cycle();
    words = '{a, b};
    model_block(words, 1);
    start = 1'b1;
    cycle();
    run_expect("late", -1, NIBS, b, -1);
    chk("late word_ready", 32'(bus.word_ready), 32'h1);
    chk("late feed drained", 32'(feed.size()), 32'h0);
    cycle();
    chk("late underrun sticky", 32'(underrun), 32'h1);
    chk("late dat_oe", 32'(dat_oe), 32'h0);

    // Reset in the middle of a block.
    preload_two(a, b);
    words = '{a, b};
    model_block(words, 2);
    start = 1'b1;
    cycle();
    run_expect("prereset", 6, -1, 32'h0, -1);
    feed.delete();
    drive_feed();
    reset = 1'b0;
    #1;
    chk("midreset serial", 32'(serial), 32'hF);
    chk("midreset dat_oe", 32'(dat_oe), 32'h0);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset complete", 32'(complete), 32'h0);
    chk("midreset underrun", 32'(underrun), 32'h0);
    chk("midreset word_ready", 32'(bus.word_ready), 32'h1);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    preload_two(a, b);
    words = '{a, b};
    model_block(words, 2);
    start = 1'b1;
    cycle();
    run_expect("postreset", -1, -1, 32'h0, -1);

    // Start re-pulsed mid-block, extra word offered during the last word.
    preload_two(a, b);
    c = $urandom;
    words = '{a, b};
    model_block(words, 2);
    start = 1'b1;
    cycle();
    run_expect("repulse", -1, NIBS + 2, c, 4);
    chk("carry word_ready", 32'(bus.word_ready), 32'h0);
    chk("carry feed drained", 32'(feed.size()), 32'h0);
    d = $urandom;
    feed.push_back(d);
    drive_feed();
    cycle();
    words = '{c, d};
    model_block(words, 2);
    start = 1'b1;
    cycle();
    run_expect("carry", -1, -1, 32'h0, -1);

    // Random back-to-back blocks with random idle gaps.
    for (int k = 0; k < 4; k++) begin
      preload_two(a, b);
      repeat ($urandom_range(0, 3)) cycle();
      words = '{a, b};
      model_block(words, 2);
      start = 1'b1;
      cycle();
      run_expect("random", -1, -1, 32'h0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
